// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch buffer.
// Latency: none (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;

  // One prefetch buffer slot: the fetch address travels with its instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t with a single-cycle flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push while full (without a pop) and a pop while empty are ignored; flush wins over both.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_dat,
  input  logic         i_pop,
  output fetch_entry_t o_head_dat,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  // A pop makes room for a same-cycle push even when full.
  assign w_pop  = i_pop  && !i_flush && !o_empty;
  assign w_push = i_push && !i_flush && (!o_full || w_pop);

  // Storage array; contents need no reset because r_count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: sequential PC, credit-limited imem requests, DEPTH-entry prefetch buffer to decode.
// Latency: if_valid two cycles after the imem_req cycle on an empty buffer; 1 instr/cycle sustained.
// Backpressure: if_ready=0 fills the buffer, then requests stop; FETCH_PERF_CNT_EN enables perf counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_pend;     // a request issued last cycle whose response is still wanted
  logic [XLEN-1:0] r_pend_pc;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_occ;
  logic            w_full;
  logic            w_empty;
  logic            w_issue;
  logic            w_accept;
  logic            w_pop;
  fetch_entry_t    w_push_dat;
  fetch_entry_t    w_head;

  // Credits: buffered entries plus the one outstanding response must stay within DEPTH.
  // Gating with RST keeps the request low during reset yet lets the first one go out
  // in the very first cycle after release.
  assign w_occ    = w_count + CW'(r_pend);
  assign w_issue  = RST && !redirect_valid && (w_occ < CW'(DEPTH));
  assign imem_req  = w_issue;
  assign imem_addr = r_fetch_pc;

  // Only the response to a live request is kept; anything from before a redirect or
  // reset finds r_pend clear and is dropped.
  assign w_accept = imem_rvalid && r_pend && !redirect_valid;
  assign w_pop    = if_valid && if_ready && !redirect_valid;

  assign w_push_dat.pc    = r_pend_pc;
  assign w_push_dat.instr = imem_rdata;

  assign if_valid = !w_empty;
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_flush    (redirect_valid),
    .i_push     (w_accept),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // Fetch PC and outstanding-request tracking; a redirect overrides sequential advance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fetch_pc <= align_pc(PC_RESET);
      r_pend     <= 1'b0;
      r_pend_pc  <= align_pc(PC_RESET);
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_pc <= r_fetch_pc;
      end
      if (redirect_valid) begin
        r_fetch_pc <= align_pc(redirect_pc);
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_INCR;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Delivered-instruction and decode-stall counters, free-running and wrapping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (if_valid && !if_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

`ifndef SYNTHESIS
  // Credit accounting means a live response can never land in a full buffer.
  a_no_overflow : assert property (@(posedge CLK) disable iff (!RST) !(w_accept && w_full));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=4) plus a PC-wrap instance.
// Latency: n/a.
// Backpressure: exercised through if_ready stalls and redirects.
module tb_instr_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic        force_stale;

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        redir2;
  logic [31:0] redirpc2;
  logic        ifv2;
  logic        ifr2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] pf2;
  logic [31:0] ps2;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.PC_RESET(32'h0000_0000), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  instr_fetch_unit #(.PC_RESET(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .CLK(CLK), .RST(rst2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect_valid(redir2), .redirect_pc(redirpc2),
    .if_valid(ifv2), .if_ready(ifr2),
    .if_instr(instr2), .if_pc(pc2),
    .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // One-cycle instruction memory; force_stale injects a response with no live request.
  always @(posedge CLK) begin
    imem_rvalid <= imem_req | force_stale;
    imem_rdata  <= force_stale ? 32'hDEAD_BEEF : word(imem_addr);
    rvalid2     <= req2;
    rdata2      <= word(addr2);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; force_stale = 1'b0;
    rst2 = 1'b0; ifr2 = 1'b1; redir2 = 1'b0; redirpc2 = 32'd0;
    repeat (3) tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b exp 0", if_valid); end
    checks++; if (perf_fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf_fetch got %0d exp 0", perf_fetch_cnt); end
    checks++; if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf_stall got %0d exp 0", perf_stall_cnt); end
    checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL reset_req_wrap got %b exp 0", req2); end
  endtask

  task automatic test_stream();
    if_ready = 1'b1; RST = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 00000000", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL c0_if_valid got %b exp 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL c1_if_valid got %b exp 0", if_valid); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL c1_addr got %h exp 00000004", imem_addr); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, if_valid); end
      checks++; if (if_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, if_pc, 32'(4 * i)); end
      checks++; if (if_instr !== word(32'(4 * i))) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, if_instr, word(32'(4 * i))); end
      checks++; if (imem_addr !== 32'(4 * (i + 2)) || imem_req !== 1'b1) begin errors++; $display("FAIL stream_addr[%0d] got %h/%b exp %h/1", i, imem_addr, imem_req, 32'(4 * (i + 2))); end
    end
  endtask

  task automatic test_redirect();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; force_stale = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_suppressed got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL redir_pre_flush_valid got %b exp 1", if_valid); end
    tick();
    redirect_valid = 1'b0; force_stale = 1'b0; if_ready = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed got %b exp 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_target got %h/%b exp 00000100/1", imem_addr, imem_req); end
    checks++; if (perf_fetch_cnt !== (PERF ? 32'd8 : 32'd0)) begin errors++; $display("FAIL redir_perf_fetch got %0d exp %0d", perf_fetch_cnt, PERF ? 8 : 0); end
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stale_dropped got %b exp 0", if_valid); end
      end
      if (imem_req === 1'b1) begin
        checks++; if (imem_addr !== 32'h100 + 32'(4 * n)) begin errors++; $display("FAIL stall_addr[%0d] got %h exp %h", n, imem_addr, 32'h100 + 32'(4 * n)); end
        n++;
      end
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL stall_req_count got %0d exp 4", n); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_off got %b exp 0", imem_req); end
    checks++; if (perf_stall_cnt !== (PERF ? 32'd10 : 32'd0)) begin errors++; $display("FAIL stall_perf got %0d exp %0d", perf_stall_cnt, PERF ? 10 : 0); end
    if_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL drain_pc[%0d] got %h/%b exp %h/1", k, if_pc, if_valid, 32'h100 + 32'(4 * k)); end
      checks++; if (if_instr !== word(32'h100 + 32'(4 * k))) begin errors++; $display("FAIL drain_instr[%0d] got %h exp %h", k, if_instr, word(32'h100 + 32'(4 * k))); end
      tick();
    end
    checks++; if (perf_fetch_cnt !== (PERF ? 32'd13 : 32'd0)) begin errors++; $display("FAIL drain_perf_fetch got %0d exp %0d", perf_fetch_cnt, PERF ? 13 : 0); end
  endtask

  task automatic test_back_to_back();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h114) begin errors++; $display("FAIL b2b_pre got %h/%b exp 00000114/1", if_pc, if_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req0 got %b exp 0", imem_req); end
    tick();
    redirect_pc = 32'h0000_3005; #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL b2b_second got valid %b req %b exp 0/0", if_valid, imem_req); end
    tick();
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin errors++; $display("FAIL b2b_target got %h/%b exp 00003004/1", imem_addr, imem_req); end
    checks++; if (perf_fetch_cnt !== (PERF ? 32'd13 : 32'd0)) begin errors++; $display("FAIL b2b_no_delivery got %0d exp %0d", perf_fetch_cnt, PERF ? 13 : 0); end
    tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h3008) begin errors++; $display("FAIL b2b_c1 got %h/%b exp 00003008/0", imem_addr, if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3004) begin errors++; $display("FAIL b2b_first_instr got %h/%b exp 00003004/1", if_pc, if_valid); end
    checks++; if (if_instr !== word(32'h3004)) begin errors++; $display("FAIL b2b_instr got %h exp %h", if_instr, word(32'h3004)); end
  endtask

  task automatic test_reset_mid();
    if_ready = 1'b0;
    tick(); tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3004) begin errors++; $display("FAIL mid_pre got %h/%b exp 00003004/1", if_pc, if_valid); end
    RST = 1'b0; force_stale = 1'b1; #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_immediate got valid %b req %b exp 0/0", if_valid, imem_req); end
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL mid_reset_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt); end
    tick();
    RST = 1'b1; force_stale = 1'b0; if_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_release_addr got %h/%b exp 00000000/1", imem_addr, imem_req); end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_dropped got %b exp 0", if_valid); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL mid_second_addr got %h exp 00000004", imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== word(32'h0)) begin errors++; $display("FAIL mid_first_instr got %h/%h/%b exp 00000000/%h/1", if_pc, if_instr, if_valid, word(32'h0)); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    rst2 = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      checks++; if (req2 !== 1'b1 || addr2 !== e) begin errors++; $display("FAIL wrap_addr[%0d] got %h/%b exp %h/1", k, addr2, req2, e); end
      if (k >= 2) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        checks++; if (ifv2 !== 1'b1 || pc2 !== e) begin errors++; $display("FAIL wrap_pc[%0d] got %h/%b exp %h/1", k, pc2, ifv2, e); end
      end
      tick();
    end
    checks++; if (pf2 !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL wrap_perf_fetch got %0d exp %0d", pf2, PERF ? 3 : 0); end
    checks++; if (ps2 !== 32'd0) begin errors++; $display("FAIL wrap_perf_stall got %0d exp 0", ps2); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_redirect();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; power of two, at least 2.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory this cycle.
REQ-006 imem_addr  output  32  word-aligned fetch address; valid when imem_req=1.
REQ-007 imem_rvalid  input  1  response valid; asserted exactly one cycle after each accepted imem_req.
REQ-008 imem_rdata  input  32  instruction word; valid when imem_rvalid=1.
REQ-009 redirect_valid  input  1  branch/jump redirect from the datapath.
REQ-010 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-011 if_valid  output  1  buffered instruction available to decode.
REQ-012 if_ready  input  1  decode accepts the instruction this cycle.
REQ-013 if_instr  output  32  instruction at buffer head.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 perf_fetch_cnt  output  32  count of instructions delivered to decode.
REQ-016 perf_stall_cnt  output  32  count of cycles with if_valid=1 and if_ready=0.

Function
REQ-017 The block shall issue imem_req=1 when (buffered + in-flight) < DEPTH and redirect_valid=0; at most one request per cycle.
REQ-018 The block shall drive imem_addr equal to the fetch PC and shall advance the fetch PC by 4 (mod 2^32) on every issued request.
REQ-019 The block shall write each imem_rvalid response into the buffer together with its request address.
REQ-020 The block shall assert if_valid whenever the buffer is non-empty, with if_instr/if_pc taken from the oldest entry.
REQ-021 The block shall pop the head entry on a cycle with if_valid=1 and if_ready=1; push and pop in the same cycle shall leave the occupancy unchanged.
REQ-022 Latency: with the buffer empty and if_ready=1, if_valid shall rise 2 cycles after the imem_req cycle; sustained throughput shall be 1 instruction per cycle.
REQ-023 The buffer shall never overflow; a response arriving while full is impossible by credit accounting and shall be flagged by a simulation assertion.
REQ-024 On redirect_valid=1: flush the buffer, load fetch PC with {redirect_pc[31:2],2'b00}, suppress imem_req that cycle, suppress the pop that cycle; flush takes priority over a simultaneous push or pop.
REQ-025 A response for a request issued before a redirect, even if it arrives the cycle after it, shall be discarded.
REQ-026 Back-to-back redirects shall each take effect; the last one determines the next fetch address.
REQ-027 Fetch PC wrap from 32'hFFFF_FFFC shall continue at 32'h0000_0000.

Reset
REQ-028 While RST=0: fetch PC=PC_RESET, buffer empty, in-flight count 0, imem_req=0, if_valid=0, perf counters 0.
REQ-029 Reset asserted mid-operation shall clear all state immediately; responses returning after reset release for pre-reset requests shall be discarded.
REQ-030 The first request shall issue in the first cycle after RST deasserts, at PC_RESET.

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined, perf_fetch_cnt shall increment on each pop and perf_stall_cnt on each stall cycle, both wrapping at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN, both perf outputs shall be constant 0 and no counter registers shall be synthesized.

Structure
REQ-033 Package fetch_pkg shall hold the instruction/address widths, the default PC_RESET, the PC increment constant and the buffer entry type {pc, instr}.
REQ-034 The buffer shall be a sub-module fetch_fifo (synchronous FIFO, flush input, full/empty/count outputs).

Verification
REQ-035 Reset release, memory returns addr-based words, if_ready=1 -> imem_addr 0,4,8,...; if_valid after 2 cycles; if_pc 0,4,8 consecutively, no gaps.
REQ-036 if_ready=0 for 10 cycles -> exactly 4 requests issued, imem_req then 0; perf_stall_cnt=10-cycle-accurate (macro on); resume -> 4 entries drained in order.
REQ-037 redirect_valid=1, redirect_pc=32'h0000_0103 with 2 responses in flight -> buffer empty next cycle, stale response dropped, next imem_addr=32'h0000_0100.
REQ-038 Redirect and if_ready=1 with if_valid=1 same cycle -> no instruction delivered; perf_fetch_cnt unchanged.
REQ-039 RST pulsed low mid-stream with 3 buffered entries -> if_valid=0 immediately; after release first imem_addr=PC_RESET.
REQ-040 PC_RESET=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; build without macro -> perf outputs stay 0.
